uart_reg_bank: RTL and testbench

- Parametrised successor to the fixed four-register UART register file.
- Holds REG_COUNT registers of DATA_WIDTH bits. Per-bit access behaviour (read-write, read-clear, write-1-to-clear) is set by flat mask parameters.
- Adds a pipelined CPU request/acknowledge bus, sticky peripheral set inputs and a registered interrupt output.
- Sits between the CPU bus adapter and the UART TX/RX/baud logic.

---
 rtl/uart_reg_bank.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_reg_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bank.sv
// -----------------------------------------------------------------------------
// uart_reg_bank
//
// Parametrised UART register file that sits between the CPU bus adapter and
// the UART TX/RX/baud logic. It holds REG_COUNT registers of DATA_WIDTH bits.
// Three flat mask parameters set how each bit responds to the CPU:
//   RW_MASKS  - bit is CPU writable
//   RC_MASKS  - bit clears when the CPU reads its register
//   W1C_MASKS - bit clears when the CPU writes 1 to it (RW takes precedence)
// Register r occupies slice [r*DATA_WIDTH +: DATA_WIDTH] of every flat vector.
//
// Per-bit update priority, highest first:
//   reset > peripheral set > peripheral load (non-RW bits) > CPU write/clear
// A peripheral set that collides with a CPU clear therefore leaves the bit at
// 1, so no hardware event is lost.
//
// CPU bus handshake: a request is accepted on every cycle with cpu_req_i=1.
// There is no back-pressure. cpu_ack_o pulses exactly one cycle after
// acceptance. cpu_rdata_o then carries the register value sampled in the
// acceptance cycle, before that cycle's updates. It is 0 for writes, for
// out-of-range reads and when idle.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   cpu_req_i       bus request, one transfer per cycle
//   cpu_we_i        1 = write, 0 = read
//   cpu_addr_i      register index (ADDR_WIDTH bits)
//   cpu_wdata_i     write data
//   cpu_ack_o       transfer complete, one cycle after the request
//   cpu_rdata_o     read data, valid while cpu_ack_o=1
//   periph_data_i   peripheral load data (flat, per register)
//   wr_en_periph_i  per-register peripheral load strobe
//   set_periph_i    sticky bit-set pulses (flat, per register)
//   data_o          live register contents (flat, straight from flops)
//   irq_o           level interrupt, registered
//   cpu_err_o       bus error flag alongside cpu_ack_o
//                   (present only when UART_REG_BUS_ERR_EN is defined)
//
// Optional feature macro: UART_REG_BUS_ERR_EN
//   When defined, cpu_err_o flags out-of-range accesses and writes to
//   registers that have no CPU-writable or W1C bits. Register behaviour
//   does not change: such writes are still ignored.
// -----------------------------------------------------------------------------
module uart_reg_bank #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 4,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] RW_MASKS =
        {32'h0, 32'hFF, 32'h037D037F, 32'h0},
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] RC_MASKS =
        {32'h0, 32'h0, 32'h0, 32'h00010001},
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] W1C_MASKS =
        {REG_COUNT*DATA_WIDTH{1'b0}},
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUES =
        {REG_COUNT*DATA_WIDTH{1'b0}},
    parameter int IRQ_STAT_IDX = 0,
    parameter int IRQ_EN_IDX   = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cpu_req_i,
    input  logic                            cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]           cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]           cpu_wdata_i,
    output logic                            cpu_ack_o,
    output logic [DATA_WIDTH-1:0]           cpu_rdata_o,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] periph_data_i,
    input  logic [REG_COUNT-1:0]            wr_en_periph_i,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] set_periph_i,
    output logic [REG_COUNT*DATA_WIDTH-1:0] data_o,
    output logic                            irq_o
`ifdef UART_REG_BUS_ERR_EN
    ,
    output logic                            cpu_err_o
`endif
);

    // -------------------------------------------------------------------------
    // Per-register views of the flat mask parameters (constants).
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rw_mask   [REG_COUNT];
    logic [DATA_WIDTH-1:0] rc_mask   [REG_COUNT];
    logic [DATA_WIDTH-1:0] w1c_mask  [REG_COUNT];
    logic [DATA_WIDTH-1:0] rst_value [REG_COUNT];

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_masks
        assign rw_mask[g]   = RW_MASKS[g*DATA_WIDTH +: DATA_WIDTH];
        assign rc_mask[g]   = RC_MASKS[g*DATA_WIDTH +: DATA_WIDTH];
        assign w1c_mask[g]  = W1C_MASKS[g*DATA_WIDTH +: DATA_WIDTH];
        assign rst_value[g] = RESET_VALUES[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] reg_q   [REG_COUNT];
    logic [DATA_WIDTH-1:0] reg_d   [REG_COUNT];
    logic                  ack_q;
    logic                  ack_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  irq_q;
    logic                  irq_d;

    // -------------------------------------------------------------------------
    // Address decode. The decode compares against each implemented index
    // instead of indexing the register array with the raw address, so an
    // out-of-range address simply matches nothing.
    // -------------------------------------------------------------------------
    logic [REG_COUNT-1:0] addr_hit;
    logic                 in_range;
    logic                 cpu_wr;
    logic                 cpu_rd;

    always_comb begin
        addr_hit = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            addr_hit[r] = (cpu_addr_i == ADDR_WIDTH'(r));
        end
        in_range = |addr_hit;
        cpu_wr   = cpu_req_i &  cpu_we_i;
        cpu_rd   = cpu_req_i & ~cpu_we_i;
    end

    // -------------------------------------------------------------------------
    // Register next-state. The updates are applied from lowest to highest
    // priority, so each later step overrides the earlier ones on the bits it
    // touches.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            reg_d[r] = reg_q[r];

            // CPU write: RW bits take the write data. W1C bits that are not
            // also RW clear where the write data is 1.
            if (cpu_wr && addr_hit[r]) begin
                reg_d[r] = (reg_d[r] & ~rw_mask[r]) | (cpu_wdata_i & rw_mask[r]);
                reg_d[r] = reg_d[r] & ~(cpu_wdata_i & w1c_mask[r] & ~rw_mask[r]);
            end

            // CPU read: read-clear bits drop at the end of the acceptance cycle.
            if (cpu_rd && addr_hit[r]) begin
                reg_d[r] = reg_d[r] & ~rc_mask[r];
            end

            // Peripheral load only reaches bits the CPU cannot write.
            if (wr_en_periph_i[r]) begin
                reg_d[r] = (reg_d[r] & rw_mask[r])
                         | (periph_data_i[r*DATA_WIDTH +: DATA_WIDTH] & ~rw_mask[r]);
            end

            // A sticky set wins over everything except reset.
            reg_d[r] = reg_d[r] | set_periph_i[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // -------------------------------------------------------------------------
    // Bus response and interrupt next-state
    // -------------------------------------------------------------------------
    always_comb begin
        ack_d   = cpu_req_i;
        rdata_d = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            if (cpu_rd && addr_hit[r]) begin
                rdata_d = reg_q[r];
            end
        end
        // The interrupt is computed from the registered (already updated)
        // contents, so it follows a register change by one cycle.
        irq_d = |(reg_q[IRQ_STAT_IDX] & reg_q[IRQ_EN_IDX]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                reg_q[r] <= rst_value[r];
            end
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                reg_q[r] <= reg_d[r];
            end
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

`ifdef UART_REG_BUS_ERR_EN
    // -------------------------------------------------------------------------
    // Bus error: out-of-range address, or a write to a register that has no
    // CPU-modifiable bit at all. The flag travels with the acknowledge.
    // -------------------------------------------------------------------------
    logic err_d;
    logic err_q;

    always_comb begin
        err_d = 1'b0;
        if (cpu_req_i && !in_range) begin
            err_d = 1'b1;
        end
        for (int r = 0; r < REG_COUNT; r++) begin
            if (cpu_wr && addr_hit[r] && ((rw_mask[r] | w1c_mask[r]) == '0)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cpu_err_o = err_q;
`else
    // in_range feeds only the error logic; it is folded here so the default
    // build leaves no dangling signal.
    logic unused_in_range;
    assign unused_in_range = in_range;
`endif

    // -------------------------------------------------------------------------
    // Outputs come straight from flops.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < REG_COUNT; g++) begin : g_data_out
        assign data_o[g*DATA_WIDTH +: DATA_WIDTH] = reg_q[g];
    end

    assign cpu_ack_o   = ack_q;
    assign cpu_rdata_o = rdata_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_bank
//
// Bench for uart_reg_bank with the default masks and RESET_VALUES slice 1 =
// 32'h5. It runs a table of directed vectors, a few hand-written multi-cycle
// sequences, and a randomized phase. Every cycle is also compared against a
// bit-level reference model of the register rules.
// -----------------------------------------------------------------------------
module tb_uart_reg_bank;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int FW = NR * DW;

    // Register rules as seen from the outside.
    localparam logic [DW-1:0] RW_M  [NR] = '{32'h0, 32'h037D037F, 32'h000000FF, 32'h0};
    localparam logic [DW-1:0] RC_M  [NR] = '{32'h00010001, 32'h0, 32'h0, 32'h0};
    localparam logic [DW-1:0] W1C_M [NR] = '{32'h0, 32'h0, 32'h0, 32'h0};
    localparam logic [DW-1:0] RST_M [NR] = '{32'h0, 32'h5, 32'h0, 32'h0};

    // ---------------------------------------------------------------- clock/reset
    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [FW-1:0] periph_data;
    logic [NR-1:0] wr_en_periph;
    logic [FW-1:0] set_periph;
    logic [FW-1:0] data_out;
    logic          irq;
`ifdef UART_REG_BUS_ERR_EN
    logic          cpu_err;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    uart_reg_bank #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .REG_COUNT    (NR),
        .RESET_VALUES ({32'h0, 32'h0, 32'h5, 32'h0})
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_req_i      (cpu_req),
        .cpu_we_i       (cpu_we),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_ack_o      (cpu_ack),
        .cpu_rdata_o    (cpu_rdata),
        .periph_data_i  (periph_data),
        .wr_en_periph_i (wr_en_periph),
        .set_periph_i   (set_periph),
        .data_o         (data_out),
        .irq_o          (irq)
`ifdef UART_REG_BUS_ERR_EN
        ,
        .cpu_err_o      (cpu_err)
`endif
    );

    // ---------------------------------------------------------------- scoreboard
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    logic [DW-1:0] m_reg [NR];
    logic          e_ack;
    logic [DW-1:0] e_rdata;
    logic          e_irq;
    logic          e_err;

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        for (int r = 0; r < NR; r++) f[r*DW +: DW] = m_reg[r];
        return f;
    endfunction

    // Advances the model by one clock edge, applying the rules bit by bit in
    // priority order.
    task automatic model_step(input logic r_rst, input logic req, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [NR-1:0] wen, input logic [FW-1:0] periph,
                              input logic [FW-1:0] setv);
        int a;
        logic [DW-1:0] nxt [NR];
        a = int'(addr);
        if (r_rst) begin
            for (int r = 0; r < NR; r++) m_reg[r] = RST_M[r];
            e_ack = 0; e_rdata = '0; e_irq = 0; e_err = 0;
            return;
        end
        e_ack   = req;
        e_rdata = (req && !we && a < NR) ? m_reg[a] : '0;
        e_irq   = |(m_reg[0] & m_reg[1]);
        e_err   = req && ((a >= NR) || (we && ((RW_M[a] | W1C_M[a]) == '0)));
        for (int r = 0; r < NR; r++) begin
            for (int b = 0; b < DW; b++) begin
                if (setv[r*DW + b])
                    nxt[r][b] = 1'b1;
                else if (wen[r] && !RW_M[r][b])
                    nxt[r][b] = periph[r*DW + b];
                else if (req && we && a == r && RW_M[r][b])
                    nxt[r][b] = wdata[b];
                else if (req && we && a == r && W1C_M[r][b] && wdata[b])
                    nxt[r][b] = 1'b0;
                else if (req && !we && a == r && RC_M[r][b])
                    nxt[r][b] = 1'b0;
                else
                    nxt[r][b] = m_reg[r][b];
            end
        end
        for (int r = 0; r < NR; r++) m_reg[r] = nxt[r];
    endtask

    // ---------------------------------------------------------------- driver
    // Drives one cycle of inputs, steps the model, then samples 1 ns after the
    // edge and compares every output with the model.
    task automatic drive(input logic r_rst, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [NR-1:0] wen, input logic [FW-1:0] periph,
                         input logic [FW-1:0] setv);
        rst          = r_rst;
        cpu_req      = req;
        cpu_we       = we;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        wr_en_periph = wen;
        periph_data  = periph;
        set_periph   = setv;
        model_step(r_rst, req, we, addr, wdata, wen, periph, setv);
        @(posedge clk);
        #1;
        check("model_data", data_out, model_flat());
        check("model_ack", FW'(cpu_ack), FW'(e_ack));
        check("model_rdata", FW'(cpu_rdata), FW'(e_rdata));
        check("model_irq", FW'(irq), FW'(e_irq));
`ifdef UART_REG_BUS_ERR_EN
        check("model_err", FW'(cpu_err), FW'(e_err));
`endif
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] set0;
        logic          ack;
        logic [DW-1:0] rdata;
        logic          irq;
        logic          err;
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [FW-1:0] pv;
        logic [FW-1:0] sv;

        //            req we  addr  wdata          set0           ack rdata          irq err r0             r1             r2
        tbl[0]  = '{1'b1,1'b1,3'd1,32'hFFFFFFFF,32'h0,        1'b1,32'h0,        1'b0,1'b0,32'h0,        32'h037D037F,32'h0};
        tbl[1]  = '{1'b1,1'b0,3'd1,32'h0,       32'h0,        1'b1,32'h037D037F, 1'b0,1'b0,32'h0,        32'h037D037F,32'h0};
        tbl[2]  = '{1'b0,1'b0,3'd0,32'h0,       32'h1,        1'b0,32'h0,        1'b0,1'b0,32'h1,        32'h037D037F,32'h0};
        tbl[3]  = '{1'b0,1'b0,3'd0,32'h0,       32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h1,        32'h037D037F,32'h0};
        tbl[4]  = '{1'b1,1'b0,3'd0,32'h0,       32'h0,        1'b1,32'h1,        1'b1,1'b0,32'h0,        32'h037D037F,32'h0};
        tbl[5]  = '{1'b0,1'b0,3'd0,32'h0,       32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h037D037F,32'h0};
        tbl[6]  = '{1'b0,1'b0,3'd0,32'h0,       32'h1,        1'b0,32'h0,        1'b0,1'b0,32'h1,        32'h037D037F,32'h0};
        tbl[7]  = '{1'b1,1'b0,3'd0,32'h0,       32'h00010000, 1'b1,32'h1,        1'b1,1'b0,32'h00010000, 32'h037D037F,32'h0};
        tbl[8]  = '{1'b0,1'b0,3'd0,32'h0,       32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h00010000, 32'h037D037F,32'h0};
        tbl[9]  = '{1'b1,1'b1,3'd2,32'hA5,      32'h0,        1'b1,32'h0,        1'b1,1'b0,32'h00010000, 32'h037D037F,32'hA5};
        tbl[10] = '{1'b1,1'b0,3'd2,32'h0,       32'h0,        1'b1,32'hA5,       1'b1,1'b0,32'h00010000, 32'h037D037F,32'hA5};
        tbl[11] = '{1'b1,1'b1,3'd1,32'h0,       32'h0,        1'b1,32'h0,        1'b1,1'b0,32'h00010000, 32'h0,       32'hA5};
        tbl[12] = '{1'b0,1'b0,3'd0,32'h0,       32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h00010000, 32'h0,       32'hA5};
        tbl[13] = '{1'b1,1'b1,3'd5,32'hDEADBEEF,32'h0,        1'b1,32'h0,        1'b0,1'b1,32'h00010000, 32'h0,       32'hA5};
        tbl[14] = '{1'b1,1'b0,3'd5,32'h0,       32'h0,        1'b1,32'h0,        1'b0,1'b1,32'h00010000, 32'h0,       32'hA5};
        tbl[15] = '{1'b1,1'b0,3'd0,32'h0,       32'h0,        1'b1,32'h00010000, 1'b0,1'b0,32'h0,        32'h0,       32'hA5};
        tbl[16] = '{1'b1,1'b1,3'd0,32'hFFFFFFFF,32'h0,        1'b1,32'h0,        1'b0,1'b1,32'h0,        32'h0,       32'hA5};
        tbl[17] = '{1'b0,1'b0,3'd0,32'h0,       32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,       32'hA5};

        // Reset that collides with every other kind of event: reset must win.
        drive(1'b1, 1'b1, 1'b1, 3'd2, 32'hFF, 4'hF, {FW{1'b1}}, {FW{1'b1}});
        check("rst_data1", FW'(data_out[DW +: DW]), FW'(32'h5));
        check("rst_ack", FW'(cpu_ack), FW'(1'b0));
        check("rst_irq", FW'(irq), FW'(1'b0));
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        check("rst_hold_data", data_out, {32'h0, 32'h0, 32'h5, 32'h0});
        idle();
        check("post_rst_ack", FW'(cpu_ack), FW'(1'b0));
        check("post_rst_irq", FW'(irq), FW'(1'b0));

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                  '0, '0, {96'h0, tbl[i].set0});
            check($sformatf("tbl%0d_ack", i), FW'(cpu_ack), FW'(tbl[i].ack));
            check($sformatf("tbl%0d_rdata", i), FW'(cpu_rdata), FW'(tbl[i].rdata));
            check($sformatf("tbl%0d_irq", i), FW'(irq), FW'(tbl[i].irq));
            check($sformatf("tbl%0d_regs", i), FW'(data_out[3*DW-1:0]),
                  FW'({tbl[i].r2, tbl[i].r1, tbl[i].r0}));
`ifdef UART_REG_BUS_ERR_EN
            check($sformatf("tbl%0d_err", i), FW'(cpu_err), FW'(tbl[i].err));
`endif
        end

        // Peripheral load on reg 1 while the CPU writes 0 to it: only the
        // non-RW bits take the load data.
        pv = '0;
        pv[DW +: DW] = 32'hFFFFFFFF;
        drive(1'b0, 1'b1, 1'b1, 3'd1, 32'h0, 4'b0010, pv, '0);
        check("load_r1", FW'(data_out[DW +: DW]), FW'(32'hFC82FC80));

        // Peripheral load on reg 0 (no RW bits): the whole word loads, and the
        // interrupt follows one cycle later.
        pv = '0;
        pv[DW-1:0] = 32'h12345678;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 4'b0001, pv, '0);
        check("load_r0", FW'(data_out[DW-1:0]), FW'(32'h12345678));
        check("load_irq_lag", FW'(irq), FW'(1'b0));
        idle();
        check("load_irq", FW'(irq), FW'(1'b1));

        // A set and a load on the same bit: the set wins.
        pv = '0;
        sv = '0;
        sv[3] = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 4'b0001, pv, sv);
        check("set_over_load", FW'(data_out[DW-1:0]), FW'(32'h8));

        // Randomized phase, checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic          r_rst;
            logic          req;
            logic [NR-1:0] wen;
            r_rst = ($urandom_range(0, 199) == 0);
            req   = ($urandom_range(0, 3) != 0);
            wen   = ($urandom_range(0, 5) == 0) ? NR'($urandom_range(0, 15)) : '0;
            pv    = {$urandom, $urandom, $urandom, $urandom};
            sv    = '0;
            if ($urandom_range(0, 2) == 0) begin
                for (int r = 0; r < NR; r++) sv[r*DW +: DW] = $urandom & $urandom & $urandom & $urandom;
            end
            drive(r_rst, req, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  $urandom, wen, pv, sv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
